alu_trace_capture: RTL
======================

// Module: alu_trace_capture
// PURPOSE
//  Hardware trace recorder for ALUSystem observables. It captures ALUOut, ALUOutFlag,
//  Address and IROut into an on-chip buffer while armed. After Stop, the buffer is
//  read back oldest-first through a request/valid handshake. It is the on-chip
//  counterpart of the bench vector driver: stimulus goes in, this records the responses.
// PARAMETERS
//  DEPTH   16               number of trace entries; must be a power of 2, >= 2
//  ADDR_W  $clog2(DEPTH)    pointer width; derived, do not override
// PORTS
//  Clock        in   1       system clock; all state updates on posedge
//  Reset        in   1       asynchronous, active-low reset
//  Arm          in   1       clear buffer and start capture; level-sampled
//  Stop         in   1       end capture; level-sampled
//  Sample_En    in   1       record the current sample this cycle (capture only)
//  ALUOut       in   8       ALU result
//  ALUOutFlag   in   4       {Z,C,N,O}
//  Address      in   8       ARF memory address output
//  IROut        in   16      instruction register output
//  Rd_Req       in   1       pop one entry (DONE only)
//  Rd_Data      out  36      {ALUOutFlag,ALUOut,Address,IROut} of the popped entry
//  Rd_Valid     out  1       Rd_Data valid; one-cycle pulse per pop
//  Count        out  ADDR_W+1 number of entries held
//  Full         out  1       Count == DEPTH
//  Busy         out  1       state == CAPTURE
//  Overflow     out  1       sticky: a sample was dropped because the buffer was full
// BEHAVIOUR
//  Reset (async, Reset=0): state=IDLE; all pointers cleared; Rd_Data=0; Rd_Valid=0;
//   Count=0; Full=0; Busy=0; Overflow=0. This takes effect mid-capture or mid-readout
//   and discards all contents.
//  FSM states: IDLE, CAPTURE, DONE.
//   IDLE: if Arm, go to CAPTURE; clear pointers, Count and Overflow.
//   CAPTURE: if Stop, go to DONE. Arm is ignored. Rd_Req is ignored.
//   DONE: if Arm, go to CAPTURE and clear as in IDLE. Arm has priority over Rd_Req
//    in the same cycle (no pop occurs).
//  Write (CAPTURE, Sample_En=1):
//   - not Full: store {ALUOutFlag,ALUOut,Address,IROut}; increment write pointer
//     (wraps modulo DEPTH) and Count.
//   - Full: drop the sample and set Overflow. Overflow clears only on Arm or Reset.
//   - Stop and Sample_En in the same cycle: the sample is recorded, then the FSM
//     enters DONE.
//  Read (DONE, Rd_Req=1, Count>0): Rd_Data <= entry at read pointer; Rd_Valid=1 on
//   the next cycle (1-cycle latency); increment read pointer (wraps); decrement Count.
//   - Rd_Req with Count=0: no pop; Rd_Valid=0; Rd_Data holds its last value.
//   - Rd_Req held high: one pop per cycle, back-to-back, until empty.
//  Rd_Valid is 0 in every cycle without a pop. Rd_Data holds its value between pops.
//  Full is combinational from Count. Busy is combinational from state.
//  The buffer is storage only; its contents are not reset (not observable until written).
// CONFIGURATION
//  ALU_TRACE_CHANGE_ONLY_EN defined: a write occurs only if the sample differs from the
//   last recorded sample. The first sample after Arm is always recorded. A dropped
//   duplicate never sets Overflow.
//  ALU_TRACE_CHANGE_ONLY_EN undefined: every Sample_En cycle in CAPTURE is recorded, as above.
// TESTING
//  1. Reset mid-capture (3 entries held) -> next cycle Count=0, Busy=0, Overflow=0,
//     Rd_Valid=0, state IDLE.
//  2. Arm; 3 samples with ALUOut=8'h05/8'h0A/8'hFF, Flag=4'b0000/4'b0000/4'b0010,
//     Address=8'h10, IROut=16'h1234; Stop; Rd_Req x3 -> Rd_Data returns the three
//     entries in order, one Rd_Valid pulse each; Count goes 3->0.
//  3. DEPTH=16: Arm, 20 Sample_En cycles, Stop -> Count=16, Full=1, Overflow=1;
//     readback returns samples 0..15.
//  4. Empty DONE, Rd_Req=1 for 2 cycles -> Rd_Valid stays 0, Count=0. Pop across wrap
//     (write 16, read 10, re-Arm, write 12, read 12) -> all data correct, no overrun.
//  5. In DONE with Count=4: Arm and Rd_Req in the same cycle -> no pop, Count=0,
//     Busy=1, Overflow=0. Stop with Sample_En in the same cycle -> that sample is stored.
//  6. ALU_TRACE_CHANGE_ONLY_EN: 5 identical samples then 1 different -> Count=2,
//     Overflow=0. Without the macro, the same stimulus -> Count=6.

Source files
------------

// File: rtl/alu_trace_capture_if.sv
// ----------------------------------------------------------------------------
// alu_trace_capture_if
// Bundles the capture-control, sample and readout signals of alu_trace_capture.
//   master : drives Arm/Stop/Sample_En, the ALU observables and Rd_Req;
//            receives Rd_Data/Rd_Valid and the Count/Full/Busy/Overflow status.
//   slave  : the recorder side (mirror of master).
// DEPTH must match the DEPTH of the attached alu_trace_capture instance.
// ----------------------------------------------------------------------------
interface alu_trace_capture_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              Arm;
    logic              Stop;
    logic              Sample_En;
    logic [7:0]        ALUOut;
    logic [3:0]        ALUOutFlag;
    logic [7:0]        Address;
    logic [15:0]       IROut;
    logic              Rd_Req;
    logic [35:0]       Rd_Data;
    logic              Rd_Valid;
    logic [ADDR_W:0]   Count;
    logic              Full;
    logic              Busy;
    logic              Overflow;

    modport master (
        output Arm, Stop, Sample_En, ALUOut, ALUOutFlag, Address, IROut, Rd_Req,
        input  Rd_Data, Rd_Valid, Count, Full, Busy, Overflow
    );

    modport slave (
        input  Arm, Stop, Sample_En, ALUOut, ALUOutFlag, Address, IROut, Rd_Req,
        output Rd_Data, Rd_Valid, Count, Full, Busy, Overflow
    );
endinterface

// File: rtl/alu_trace_capture.sv
// ----------------------------------------------------------------------------
// alu_trace_capture
// Trace recorder for ALU observables. While armed (Busy) each Sample_En cycle
// stores {ALUOutFlag, ALUOut, Address, IROut} into a DEPTH-entry circular
// buffer. After Stop the entries are popped oldest-first with Rd_Req; each pop
// returns its entry on Rd_Data one cycle later with a single Rd_Valid pulse.
// Ports:
//   Clock  : system clock, rising edge
//   Reset  : asynchronous, active-low; discards all contents
//   bus    : alu_trace_capture_if.slave (control, samples, readout, status)
// Optional feature:
//   ALU_TRACE_CHANGE_ONLY_EN : when defined, a sample is recorded only if it
//   differs from the last recorded one (first sample after Arm always kept);
//   suppressed duplicates never set Overflow.
// ----------------------------------------------------------------------------
module alu_trace_capture #(
    parameter int unsigned DEPTH = 16
) (
    input logic              Clock,
    input logic              Reset,
    alu_trace_capture_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CntFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CntOne  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e              state_q, state_d;
    logic [35:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [35:0]         rd_data_q;
    logic                rd_valid_q;
    logic                overflow_q;

    logic [35:0]         sample;
    logic                full;
    logic                is_new;
    logic                clear;
    logic                push_req;
    logic                push;
    logic                drop;
    logic                pop;

    assign sample = {bus.ALUOutFlag, bus.ALUOut, bus.Address, bus.IROut};
    assign full   = (count_q == CntFull);

`ifdef ALU_TRACE_CHANGE_ONLY_EN
    // Last sample actually written; last_vld_q drops on Arm so the first
    // sample of a new capture is never treated as a duplicate.
    logic [35:0] last_q;
    logic        last_vld_q;

    assign is_new = ~last_vld_q | (sample != last_q);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (clear) begin
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_q     <= sample;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign is_new = 1'b1;
`endif

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.Arm)  state_d = StCapture;
            StCapture: if (bus.Stop) state_d = StDone;
            StDone:    if (bus.Arm)  state_d = StCapture;
            default:   state_d = StIdle;
        endcase
    end

    // Control outputs; Arm wins over Rd_Req in DONE, and Arm is ignored in CAPTURE
    always_comb begin
        clear    = 1'b0;
        push_req = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            StIdle:    clear = bus.Arm;
            StCapture: push_req = bus.Sample_En & is_new;
            StDone: begin
                clear = bus.Arm;
                pop   = ~bus.Arm & bus.Rd_Req & (count_q != '0);
            end
            default: ;
        endcase
    end

    assign push = push_req & ~full;
    assign drop = push_req & full;

    // Pointers, occupancy, readout register and sticky overflow
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (clear) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                // push and pop live in different states, never together
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    count_q  <= count_q + CntOne;
                end
                if (pop) begin
                    rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
                    count_q   <= count_q - CntOne;
                    rd_data_q <= mem[rd_ptr_q];
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Storage only; unwritten entries are never observable
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr_q] <= sample;
        end
    end

    assign bus.Rd_Data  = rd_data_q;
    assign bus.Rd_Valid = rd_valid_q;
    assign bus.Count    = count_q;
    assign bus.Full     = full;
    assign bus.Busy     = (state_q == StCapture);
    assign bus.Overflow = overflow_q;
endmodule
